// File: rtl/wt_store_l15_adapter.sv
// Write-through store issue stage: splits one 64-bit store into aligned L1.5 STORE_RQ
// packets, allocating a threadid per packet and freeing it on the matching ST_ACK.
module wt_store_l15_adapter #(
  parameter int TID_W   = 3,
  parameter int PADDR_W = 40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               st_valid_i,
  output logic               st_ready_o,
  input  logic [PADDR_W-1:0] st_paddr_i,
  input  logic [63:0]        st_data_i,
  input  logic [7:0]         st_be_i,
  input  logic               st_nc_i,
  output logic               l15_val_o,
  output logic [4:0]         l15_rqtype_o,
  output logic               l15_nc_o,
  output logic [2:0]         l15_size_o,
  output logic [TID_W-1:0]   l15_threadid_o,
  output logic [PADDR_W-1:0] l15_address_o,
  output logic [63:0]        l15_data_o,
  input  logic               l15_header_ack_i,
  input  logic               l15_rtrn_val_i,
  input  logic [3:0]         l15_rtrn_type_i,
  input  logic [TID_W-1:0]   l15_rtrn_threadid_i,
  output logic [TID_W:0]     outstanding_o,
  output logic               idle_o
);

  localparam int NTID = 2**TID_W;
  localparam logic [3:0] ST_ACK = 4'b0100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic [PADDR_W-4:0] line_q;
  logic [63:0]        data_q;
  logic               nc_q;
  logic [7:0]         rem_q;
  logic [NTID-1:0]    busy_q;
  logic               tid_lock_q;
  logic [TID_W-1:0]   tid_held_q;

  logic [1:0]         size;
  logic [2:0]         off;
  logic [5:0]         bit_off;
  logic [7:0]         pm;
  logic [7:0]         rem_next;
  logic [63:0]        rep_data;
  logic               any_free;
  logic [TID_W-1:0]   low_free;
  logic [TID_W-1:0]   tid;
  logic               accept;
  logic               issue;
  logic               fire;
  logic [NTID-1:0]    alloc_mask;
  logic [NTID-1:0]    free_mask;
  logic [TID_W:0]     count;
  logic               unused_paddr;

  assign unused_paddr = ^st_paddr_i[2:0];

  // Largest aligned chunk that exactly matches the remaining mask, else lowest single byte.
  always_comb begin
    size = 2'd0;
    off  = 3'd0;
    case (rem_q)
      8'hFF: begin size = 2'd3; off = 3'd0; end
      8'h0F: begin size = 2'd2; off = 3'd0; end
      8'hF0: begin size = 2'd2; off = 3'd4; end
      8'h03: begin size = 2'd1; off = 3'd0; end
      8'h0C: begin size = 2'd1; off = 3'd2; end
      8'h30: begin size = 2'd1; off = 3'd4; end
      8'hC0: begin size = 2'd1; off = 3'd6; end
      default: begin
        for (int i = 7; i >= 0; i--) begin
          if (rem_q[i]) off = 3'(i);
        end
      end
    endcase
  end

  assign bit_off = {off, 3'b000};

  always_comb begin
    pm       = 8'h00;
    rep_data = data_q;
    case (size)
      2'd0: begin
        pm       = 8'h01 << off;
        rep_data = {8{data_q[bit_off +: 8]}};
      end
      2'd1: begin
        pm       = 8'h03 << off;
        rep_data = {4{data_q[bit_off +: 16]}};
      end
      2'd2: begin
        pm       = 8'h0F << off;
        rep_data = {2{data_q[bit_off +: 32]}};
      end
      default: begin
        pm       = 8'hFF;
        rep_data = data_q;
      end
    endcase
  end

  assign rem_next = rem_q & ~pm;

  always_comb begin
    any_free = 1'b0;
    low_free = '0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        low_free = TID_W'(i);
      end
    end
  end

  // Once a packet is presented its threadid is pinned, so a concurrent free of a lower slot cannot disturb it.
  assign tid        = tid_lock_q ? tid_held_q : low_free;
  assign accept     = st_valid_i && (state_q == IDLE);
  assign issue      = (state_q == BUSY) && any_free;
  assign fire       = issue && l15_header_ack_i;
  assign alloc_mask = fire ? (NTID'(1) << tid) : '0;
  assign free_mask  = (l15_rtrn_val_i && (l15_rtrn_type_i == ST_ACK)) ?
                      (NTID'(1) << l15_rtrn_threadid_i) : '0;

  always_comb begin
    count = '0;
    for (int i = 0; i < NTID; i++) begin
      count = count + (TID_W+1)'(busy_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (st_be_i != 8'h00)) state_d = BUSY;
      BUSY: if (fire && (rem_next == 8'h00)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q     <= '0;
      data_q     <= '0;
      nc_q       <= 1'b0;
      rem_q      <= 8'h00;
      busy_q     <= '0;
      tid_lock_q <= 1'b0;
      tid_held_q <= '0;
    end else begin
      if (accept) begin
        line_q <= st_paddr_i[PADDR_W-1:3];
        data_q <= st_data_i;
        nc_q   <= st_nc_i;
        rem_q  <= st_be_i;
      end else if (fire) begin
        rem_q <= rem_next;
      end
      busy_q <= (busy_q & ~free_mask) | alloc_mask;
      if (fire) begin
        tid_lock_q <= 1'b0;
      end else if (issue) begin
        tid_lock_q <= 1'b1;
        tid_held_q <= tid;
      end
    end
  end

  assign st_ready_o     = (state_q == IDLE);
  assign l15_val_o      = issue;
  assign l15_rqtype_o   = 5'b00001;
  assign l15_nc_o       = nc_q;
  assign l15_size_o     = {1'b0, size};
  assign l15_threadid_o = tid;
  assign l15_address_o  = {line_q, off};
  assign l15_data_o     = rep_data;
  assign outstanding_o  = count;
  assign idle_o         = (state_q == IDLE) && (count == '0);

endmodule

// File: tb/tb_wt_store_l15_adapter.sv
// Directed bench for wt_store_l15_adapter: table of single stores plus hand-written
// sequences for zero-mask, return filtering, threadid exhaustion and mid-split reset.
module tb_wt_store_l15_adapter;

  localparam int TID_W   = 3;
  localparam int PADDR_W = 40;

  logic               clk;
  logic               rst;
  logic               st_valid;
  logic               st_ready;
  logic [PADDR_W-1:0] st_paddr;
  logic [63:0]        st_data;
  logic [7:0]         st_be;
  logic               st_nc;
  logic               l15_val;
  logic [4:0]         l15_rqtype;
  logic               l15_nc;
  logic [2:0]         l15_size;
  logic [TID_W-1:0]   l15_threadid;
  logic [PADDR_W-1:0] l15_address;
  logic [63:0]        l15_data;
  logic               header_ack;
  logic               rtrn_val;
  logic [3:0]         rtrn_type;
  logic [TID_W-1:0]   rtrn_tid;
  logic [TID_W:0]     outstanding;
  logic               idle;

  int nvec = 0;
  int nmis = 0;

  wt_store_l15_adapter #(.TID_W(TID_W), .PADDR_W(PADDR_W)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .st_valid_i          (st_valid),
    .st_ready_o          (st_ready),
    .st_paddr_i          (st_paddr),
    .st_data_i           (st_data),
    .st_be_i             (st_be),
    .st_nc_i             (st_nc),
    .l15_val_o           (l15_val),
    .l15_rqtype_o        (l15_rqtype),
    .l15_nc_o            (l15_nc),
    .l15_size_o          (l15_size),
    .l15_threadid_o      (l15_threadid),
    .l15_address_o       (l15_address),
    .l15_data_o          (l15_data),
    .l15_header_ack_i    (header_ack),
    .l15_rtrn_val_i      (rtrn_val),
    .l15_rtrn_type_i     (rtrn_type),
    .l15_rtrn_threadid_i (rtrn_tid),
    .outstanding_o       (outstanding),
    .idle_o              (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        nc;
    int          npkt;
    logic [2:0]  size0;
    logic [39:0] addr0;
    logic [63:0] data0;
    logic [2:0]  size1;
    logic [39:0] addr1;
    logic [63:0] data1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_store(input logic [39:0] paddr, input logic [63:0] data,
                             input logic [7:0] be, input logic nc);
    int n = 0;
    while (!st_ready && n < 50) begin
      tick();
      n++;
    end
    check("store_ready", st_ready, 1);
    st_valid = 1'b1;
    st_paddr = paddr;
    st_data  = data;
    st_be    = be;
    st_nc    = nc;
    tick();
    st_valid = 1'b0;
    st_be    = 8'h00;
  endtask

  task automatic expect_packet(input string name, input logic [2:0] size, input logic [39:0] addr,
                               input logic [63:0] data, input logic [TID_W-1:0] tid, input logic nc);
    int n = 0;
    while (!l15_val && n < 50) begin
      tick();
      n++;
    end
    check({name, "_val"}, l15_val, 1);
    check({name, "_rqtype"}, l15_rqtype, 5'b00001);
    check({name, "_size"}, l15_size, size);
    check({name, "_addr"}, l15_address, addr);
    check({name, "_data"}, l15_data, data);
    check({name, "_tid"}, l15_threadid, tid);
    check({name, "_nc"}, l15_nc, nc);
    tick();
    check({name, "_hold_val"}, l15_val, 1);
    check({name, "_hold_data"}, l15_data, data);
    check({name, "_hold_tid"}, l15_threadid, tid);
    header_ack = 1'b1;
    tick();
    header_ack = 1'b0;
  endtask

  task automatic send_rtrn(input logic [3:0] rtype, input logic [TID_W-1:0] tid);
    rtrn_val  = 1'b1;
    rtrn_type = rtype;
    rtrn_tid  = tid;
    tick();
    rtrn_val  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{40'h00_8000_1008, 64'h1122334455667788, 8'hFF, 1'b0, 1,
                3'd3, 40'h00_8000_1008, 64'h1122334455667788, 3'd0, 40'h0, 64'h0};
    vecs[1] = '{40'h00_8000_2000, 64'hAABBCCDD00000000, 8'hF0, 1'b0, 1,
                3'd2, 40'h00_8000_2004, 64'hAABBCCDDAABBCCDD, 3'd0, 40'h0, 64'h0};
    vecs[2] = '{40'h00_8000_3010, 64'h0000000000330011, 8'h05, 1'b0, 2,
                3'd0, 40'h00_8000_3010, 64'h1111111111111111,
                3'd0, 40'h00_8000_3012, 64'h3333333333333333};
    vecs[3] = '{40'h12_3456_7FF8, 64'h00000000BEEF0000, 8'h0C, 1'b1, 1,
                3'd1, 40'h12_3456_7FFA, 64'hBEEFBEEFBEEFBEEF, 3'd0, 40'h0, 64'h0};
    vecs[4] = '{40'h00_0000_1007, 64'h1234567890ABCDEF, 8'h0F, 1'b0, 1,
                3'd2, 40'h00_0000_1000, 64'h90ABCDEF90ABCDEF, 3'd0, 40'h0, 64'h0};
    vecs[5] = '{40'h00_0000_0040, 64'h000000AABB000000, 8'h18, 1'b0, 2,
                3'd0, 40'h00_0000_0043, 64'hBBBBBBBBBBBBBBBB,
                3'd0, 40'h00_0000_0044, 64'hAAAAAAAAAAAAAAAA};

    rst        = 1'b1;
    st_valid   = 1'b0;
    st_paddr   = '0;
    st_data    = '0;
    st_be      = '0;
    st_nc      = 1'b0;
    header_ack = 1'b0;
    rtrn_val   = 1'b0;
    rtrn_type  = 4'h0;
    rtrn_tid   = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_ready", st_ready, 1);
    check("rst_val", l15_val, 0);
    check("rst_out", outstanding, 0);
    check("rst_idle", idle, 1);
    check("rst_size", l15_size, 0);
    check("rst_addr", l15_address, 0);
    check("rst_data", l15_data, 0);
    check("rst_tid", l15_threadid, 0);

    for (int v = 0; v < 6; v++) begin
      check("vec_pre_out", outstanding, 0);
      apply_store(vecs[v].paddr, vecs[v].data, vecs[v].be, vecs[v].nc);
      check("vec_latency", l15_val, 1);
      expect_packet("vec_p0", vecs[v].size0, vecs[v].addr0, vecs[v].data0, 3'd0, vecs[v].nc);
      if (vecs[v].npkt == 2) begin
        check("vec_mid_ready", st_ready, 0);
        expect_packet("vec_p1", vecs[v].size1, vecs[v].addr1, vecs[v].data1, 3'd1, vecs[v].nc);
      end
      check("vec_done_ready", st_ready, 1);
      check("vec_out", outstanding, (TID_W+1)'(vecs[v].npkt));
      send_rtrn(4'b0100, 3'd0);
      if (vecs[v].npkt == 2) send_rtrn(4'b0100, 3'd1);
      check("vec_drain_out", outstanding, 0);
      check("vec_drain_idle", idle, 1);
    end

    // A zero byte-enable store is swallowed without emitting a packet.
    apply_store(40'h00_0000_5000, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b0);
    check("be0_val", l15_val, 0);
    check("be0_ready", st_ready, 1);
    check("be0_idle", idle, 1);
    tick();
    check("be0_val_later", l15_val, 0);

    // Only ST_ACK for a busy threadid changes the outstanding count.
    apply_store(40'h00_0000_6000, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
    expect_packet("ret_p0", 3'd3, 40'h00_0000_6000, 64'h0123456789ABCDEF, 3'd0, 1'b0);
    check("ret_out1", outstanding, 1);
    send_rtrn(4'b0000, 3'd0);
    check("ret_nonack", outstanding, 1);
    send_rtrn(4'b0100, 3'd3);
    check("ret_freetid", outstanding, 1);
    send_rtrn(4'b0100, 3'd0);
    check("ret_ack", outstanding, 0);
    send_rtrn(4'b0100, 3'd0);
    check("ret_dup", outstanding, 0);
    check("ret_idle", idle, 1);

    // Fill all eight threadids, then free tid 5 and watch the ninth packet take it.
    apply_store(40'h00_0000_2000, 64'h8877665544332211, 8'h55, 1'b0);
    expect_packet("ex_a0", 3'd0, 40'h00_0000_2000, 64'h1111111111111111, 3'd0, 1'b0);
    expect_packet("ex_a1", 3'd0, 40'h00_0000_2002, 64'h3333333333333333, 3'd1, 1'b0);
    expect_packet("ex_a2", 3'd0, 40'h00_0000_2004, 64'h5555555555555555, 3'd2, 1'b0);
    expect_packet("ex_a3", 3'd0, 40'h00_0000_2006, 64'h7777777777777777, 3'd3, 1'b0);
    apply_store(40'h00_0000_2000, 64'h8877665544332211, 8'hAB, 1'b0);
    expect_packet("ex_b0", 3'd0, 40'h00_0000_2000, 64'h1111111111111111, 3'd4, 1'b0);
    expect_packet("ex_b1", 3'd0, 40'h00_0000_2001, 64'h2222222222222222, 3'd5, 1'b0);
    expect_packet("ex_b2", 3'd0, 40'h00_0000_2003, 64'h4444444444444444, 3'd6, 1'b0);
    expect_packet("ex_b3", 3'd0, 40'h00_0000_2005, 64'h6666666666666666, 3'd7, 1'b0);
    check("ex_full_val", l15_val, 0);
    check("ex_full_out", outstanding, 8);
    check("ex_full_ready", st_ready, 0);
    for (int k = 0; k < 3; k++) tick();
    check("ex_stall_val", l15_val, 0);
    send_rtrn(4'b0100, 3'd5);
    check("ex_resume_val", l15_val, 1);
    check("ex_resume_tid", l15_threadid, 5);
    check("ex_resume_addr", l15_address, 40'h00_0000_2007);
    check("ex_resume_data", l15_data, 64'h8888888888888888);
    check("ex_resume_out", outstanding, 7);
    header_ack = 1'b1;
    rtrn_val   = 1'b1;
    rtrn_type  = 4'b0100;
    rtrn_tid   = 3'd2;
    tick();
    header_ack = 1'b0;
    rtrn_val   = 1'b0;
    check("ex_swap_out", outstanding, 7);
    check("ex_done_ready", st_ready, 1);
    for (int t = 0; t < 8; t++) send_rtrn(4'b0100, 3'(t));
    check("ex_drain_out", outstanding, 0);
    check("ex_drain_idle", idle, 1);

    // Reset while the second byte of a split store (rem=0x04) is still pending.
    apply_store(40'h00_0000_3000, 64'h0000000000330011, 8'h05, 1'b0);
    expect_packet("mr_p0", 3'd0, 40'h00_0000_3000, 64'h1111111111111111, 3'd0, 1'b0);
    check("mr_pre_val", l15_val, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_ready", st_ready, 1);
    check("mr_val", l15_val, 0);
    check("mr_out", outstanding, 0);
    check("mr_idle", idle, 1);
    check("mr_size", l15_size, 0);
    check("mr_addr", l15_address, 0);
    check("mr_data", l15_data, 0);
    check("mr_tid", l15_threadid, 0);
    check("mr_nc", l15_nc, 0);
    for (int k = 0; k < 3; k++) tick();
    check("mr_no_pkt", l15_val, 0);
    send_rtrn(4'b0100, 3'd0);
    check("mr_late_ack", outstanding, 0);
    check("mr_late_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
